reg_dump_reader: RTL and testbench

Debug readout engine for the MIPS datapath register file. On a start pulse it walks the register-file read port over addresses 0..NUM_REGS-1. It captures each word and streams it out as (address, data) beats on a valid/ready interface, for a trace/UART bridge or a testbench scoreboard. It is the read-side counterpart of the register file's write port and uses one spare combinational read port.

---
 rtl/reg_dump_pkg.sv | 20 ++
 rtl/reg_dump_reader.sv | 201 ++++++++++++++++++++
 tb/tb_reg_dump_reader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
// Optional feature macro: REG_DUMP_CHECKSUM_EN adds the CSUM state used to
// emit a trailing checksum beat.
package reg_dump_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM,
`endif
    FIN
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a combinational register-file read port over
// addresses 0..NUM_REGS-1 and streams each word out as an (address, data)
// beat on a valid/ready interface.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   start            one-cycle dump request, ignored while busy
//   rdAddr / rdData  register-file read port (data valid in same cycle)
//   outValid/outReady beat handshake
//   outAddr/outData  beat payload, held stable until accepted
//   outLast          final beat of a dump
//   outCsum          beat carries the checksum (0 without the macro)
//   busy, done       dump in progress; one-cycle completion pulse
//
// Macro REG_DUMP_CHECKSUM_EN: accumulate all dumped words modulo 2^DATA_W and
// append one checksum beat (outAddr=0, outCsum=1, outLast=1) after the last
// register beat.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [DATA_W-1:0] rdData,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W-1:0] outAddr,
  output logic [DATA_W-1:0] outData,
  output logic              outLast,
  output logic              outCsum,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              handshake;
  logic              idx_at_last;

`ifdef REG_DUMP_CHECKSUM_EN
  logic              out_csum_q, out_csum_d;
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign handshake   = out_valid_q & outReady;
  assign idx_at_last = (idx_q == LAST_IDX);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      out_csum_q  <= 1'b0;
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      out_csum_q  <= out_csum_d;
      sum_q       <= sum_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    out_csum_d  = out_csum_q;
    sum_d       = sum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // rdAddr is registered, so it is pointed at index 0 on entry to READ
          idx_d     = '0;
          rd_addr_d = '0;
          busy_d    = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          sum_d     = '0;
`endif
          state_d   = READ;
        end
      end

      READ: begin
        out_data_d  = rdData;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        out_csum_d  = 1'b0;
        sum_d       = sum_q + rdData;
`else
        out_last_d  = idx_at_last;
`endif
        state_d     = SEND;
      end

      SEND: begin
        if (handshake) begin
          out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          if (out_csum_q) begin
            state_d = FIN;
          end else if (idx_at_last) begin
            state_d = CSUM;
          end else begin
            idx_d     = idx_q + ADDR_W'(1);
            rd_addr_d = idx_q + ADDR_W'(1);
            state_d   = READ;
          end
`else
          if (idx_at_last) begin
            state_d = FIN;
          end else begin
            idx_d     = idx_q + ADDR_W'(1);
            rd_addr_d = idx_q + ADDR_W'(1);
            state_d   = READ;
          end
`endif
        end
      end

`ifdef REG_DUMP_CHECKSUM_EN
      // Load the checksum beat; mirrors READ so the beat rate stays 1 per 2
      CSUM: begin
        out_data_d  = sum_q;
        out_addr_d  = '0;
        out_csum_d  = 1'b1;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
`endif

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdAddr   = rd_addr_q;
  assign outValid = out_valid_q;
  assign outAddr  = out_addr_q;
  assign outData  = out_data_q;
  assign outLast  = out_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef REG_DUMP_CHECKSUM_EN
  assign outCsum  = out_csum_q;
`else
  assign outCsum  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: random register contents and
// random downstream backpressure, checked against a list of expected beats
// built directly from the register array contents.
module tb_reg_dump_reader;

  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB = NR + CS;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic          out_valid, out_last, out_csum, busy, done;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic [DW-1:0] regs [NR];

  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rdAddr   (rd_addr),
    .rdData   (rd_data),
    .outValid (out_valid),
    .outReady (out_ready),
    .outAddr  (out_addr),
    .outData  (out_data),
    .outLast  (out_last),
    .outCsum  (out_csum),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          last;
    logic          csum;
  } beat_t;

  int    tests_run = 0;
  int    tests_failed = 0;
  beat_t got[$];
  beat_t exp_q[$];
  int    done_cycle, done_count, stable_err;
  bit    stopped;

  // Expected stream: every register in order, then the checksum beat if enabled
  function automatic void build_expected();
    logic [DW-1:0] sum;
    beat_t b;
    exp_q.delete();
    sum = '0;
    for (int i = 0; i < NR; i++) begin
      b.a = AW'(i);
      b.d = regs[i];
      b.last = (i == NR - 1) && (CS == 0);
      b.csum = 1'b0;
      exp_q.push_back(b);
      sum = sum + regs[i];
    end
    if (CS != 0) begin
      b.a = '0;
      b.d = sum;
      b.last = 1'b1;
      b.csum = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  // Drives one dump (start already raised by caller) and records accepted beats.
  // Cycle c counts edges after the start edge. Negative beat arguments disable
  // the corresponding action.
  task automatic collect(input int ready_pct, input int stall_beat,
                         input int restart_beat, input int write_reg,
                         input int stop_beat, input int budget);
    beat_t cur, prev;
    bit held, stalled, restarted, written;
    int stall_left;
    got.delete();
    done_cycle = -1; done_count = 0; stable_err = 0; stopped = 0;
    held = 0; stalled = 0; restarted = 0; written = 0; stall_left = 0;
    prev = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cycle >= 0 && c >= done_cycle + 3) break;
      if (!written && write_reg >= 0 && got.size() == 5) begin
        regs[write_reg] = 32'hDEADBEEF;
        written = 1;
      end
      if (!restarted && restart_beat >= 0 && got.size() == restart_beat) begin
        start = 1'b1;
        restarted = 1;
      end
      cur.a = out_addr; cur.d = out_data; cur.last = out_last; cur.csum = out_csum;
      if (out_valid) begin
        if (held && cur !== prev) stable_err++;
        if (stop_beat >= 0 && got.size() == stop_beat) begin
          out_ready = 1'b0;
          stopped = 1;
          return;
        end
        if (!stalled && stall_beat >= 0 && got.size() == stall_beat) begin
          stalled = 1;
          stall_left = 5;
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (out_ready) begin
          got.push_back(cur);
          held = 0;
        end else begin
          held = 1;
          prev = cur;
        end
      end else begin
        if (held) stable_err++;
        held = 0;
        out_ready = ($urandom_range(99) < ready_pct);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done); end
    tests_run++; if (out_addr !== '0) begin tests_failed++; $display("FAIL reset_addr got=%0d exp=0", out_addr); end
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_data got=%h exp=0", out_data); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got=%b exp=0", out_last); end
    tests_run++; if (out_csum !== 1'b0) begin tests_failed++; $display("FAIL reset_csum got=%b exp=0", out_csum); end
    tests_run++; if (rd_addr !== '0) begin tests_failed++; $display("FAIL reset_rdaddr got=%0d exp=0", rd_addr); end
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < NR; i++) regs[i] = (CS != 0) ? 32'(i) : 32'h100 + 32'(i);
    build_expected();
    start = 1'b1;
    collect(100, -1, -1, -1, -1, 400);
    tests_run++;
    if (got.size() !== exp_q.size()) begin
      tests_failed++; $display("FAIL full_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL full_beat%0d got a=%0d d=%h l=%b c=%b exp a=%0d d=%h l=%b c=%b", i,
                 got[i].a, got[i].d, got[i].last, got[i].csum,
                 exp_q[i].a, exp_q[i].d, exp_q[i].last, exp_q[i].csum);
      end
    end
    tests_run++;
    if (done_cycle !== 2 * NR + 1 + 2 * CS) begin
      tests_failed++; $display("FAIL full_done_latency got=%0d exp=%0d", done_cycle, 2 * NR + 1 + 2 * CS);
    end
    tests_run++;
    if (done_count !== 1) begin tests_failed++; $display("FAIL full_done_pulses got=%0d exp=1", done_count); end
`ifdef REG_DUMP_CHECKSUM_EN
    tests_run++;
    if (got.size() == NB && got[NB-1].d !== 32'd496) begin
      tests_failed++; $display("FAIL full_csum_value got=%0d exp=496", got[NB-1].d);
    end
`endif
  endtask

  task automatic test_random_backpressure();
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    build_expected();
    start = 1'b1;
    collect(55, -1, -1, -1, -1, 3000);
    tests_run++;
    if (got.size() !== exp_q.size()) begin
      tests_failed++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rand_beat%0d got a=%0d d=%h exp a=%0d d=%h", i, got[i].a, got[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    tests_run++;
    if (stable_err !== 0) begin tests_failed++; $display("FAIL rand_stability got=%0d exp=0", stable_err); end
    tests_run++;
    if (done_count !== 1) begin tests_failed++; $display("FAIL rand_done_pulses got=%0d exp=1", done_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < NR; i++) regs[i] = 32'h100 + 32'(i);
    build_expected();
    start = 1'b1;
    collect(100, 7, -1, -1, -1, 400);
    tests_run++;
    if (got.size() !== exp_q.size()) begin
      tests_failed++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), exp_q.size());
    end
    tests_run++;
    if (got.size() > 8 && (got[7] !== exp_q[7] || got[8] !== exp_q[8])) begin
      tests_failed++; $display("FAIL stall_beats7_8 got=%0d/%h,%0d/%h exp=7/%h,8/%h",
                               got[7].a, got[7].d, got[8].a, got[8].d, exp_q[7].d, exp_q[8].d);
    end
    tests_run++;
    if (stable_err !== 0) begin tests_failed++; $display("FAIL stall_stability got=%0d exp=0", stable_err); end
    tests_run++;
    if (done_cycle !== 2 * NR + 1 + 2 * CS + 5) begin
      tests_failed++; $display("FAIL stall_done_latency got=%0d exp=%0d", done_cycle, 2 * NR + 6 + 2 * CS);
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    build_expected();
    start = 1'b1;
    collect(100, -1, 10, -1, -1, 400);
    tests_run++;
    if (got.size() !== NB) begin tests_failed++; $display("FAIL busy_start_count got=%0d exp=%0d", got.size(), NB); end
    tests_run++;
    if (done_count !== 1) begin tests_failed++; $display("FAIL busy_start_done got=%0d exp=1", done_count); end
    tests_run++;
    if (got.size() == NB && got[NB-1] !== exp_q[NB-1]) begin
      tests_failed++; $display("FAIL busy_start_final got=%h exp=%h", got[NB-1].d, exp_q[NB-1].d);
    end
  endtask

  task automatic test_reset_abort();
    int extra_done;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    start = 1'b1;
    collect(100, -1, -1, -1, 15, 400);
    tests_run++;
    if (stopped !== 1'b1 || out_addr !== AW'(15)) begin
      tests_failed++; $display("FAIL abort_reach15 got stopped=%b addr=%0d exp stopped=1 addr=15", stopped, out_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", busy); end
    extra_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) extra_done++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (extra_done !== 0) begin tests_failed++; $display("FAIL abort_no_done got=%0d exp=0", extra_done); end
    build_expected();
    out_ready = 1'b1;
    start = 1'b1;
    collect(100, -1, -1, -1, -1, 400);
    tests_run++;
    if (got.size() !== NB || got[0] !== exp_q[0]) begin
      tests_failed++; $display("FAIL abort_restart got count=%0d exp=%0d", got.size(), NB);
    end
  endtask

  task automatic test_write_during_dump();
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    regs[20] = 32'h0;
    start = 1'b1;
    collect(80, -1, -1, 20, -1, 2000);
    build_expected();
    tests_run++;
    if (got.size() <= 20 || got[20].d !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL write_reg20 got=%h exp=deadbeef", (got.size() > 20) ? got[20].d : 32'hx);
    end
    tests_run++;
    if (got.size() !== exp_q.size() || got[NB-1] !== exp_q[NB-1]) begin
      tests_failed++; $display("FAIL write_final count=%0d exp=%0d", got.size(), exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = '0;
    test_reset();
    test_full_dump();
    test_random_backpressure();
    test_stall();
    test_start_while_busy();
    test_reset_abort();
    test_write_during_dump();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
